i2s_clkgen: RTL and testbench



---
 rtl/i2s_clkgen_pkg.sv | 21 ++
 rtl/i2s_clkdiv.sv | 46 ++++
 rtl/i2s_clkgen.sv | 80 ++++++++
 tb/tb_i2s_clkgen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/i2s_clkgen_pkg.sv
// i2s_clkgen_pkg: clock generator state encodings, slot length codes and code-to-length mapping
package i2s_clkgen_pkg;

    localparam logic [1:0] I2S_DAT_8  = 2'd0;
    localparam logic [1:0] I2S_DAT_16 = 2'd1;
    localparam logic [1:0] I2S_DAT_24 = 2'd2;
    localparam logic [1:0] I2S_DAT_32 = 2'd3;

    typedef enum logic [1:0] {
        I2S_CLKGEN_IDLE = 2'd0,
        I2S_CLKGEN_RUN  = 2'd1,
        I2S_CLKGEN_STOP = 2'd2
    } clkgen_state_t;

    function automatic logic [5:0] slot_len(input logic [1:0] chl);
        logic [2:0] n;
        n = {1'b0, chl} + 3'd1;
        return {n, 3'b000};
    endfunction

endpackage

// File: rtl/i2s_clkdiv.sv
// i2s_clkdiv: half-period divider producing sck with registered edge strobes
module i2s_clkdiv #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 sck_o,
    output logic                 re_o,
    output logic                 fe_o,
    output logic                 fall_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sck_q, sck_d, re_q, re_d, fe_q, fe_d, tick;

    // fall_o announces the falling edge one cycle early so ws can change with it
    always_comb begin
        tick   = en_i && (cnt_q == div_i);
        cnt_d  = !en_i ? '0 : tick ? '0 : cnt_q + DIV_WIDTH'(1);
        sck_d  = en_i && (sck_q ^ tick);
        re_d   = tick && !sck_q;
        fe_d   = tick && sck_q;
        fall_o = fe_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
            re_q  <= 1'b0;
            fe_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
            re_q  <= re_d;
            fe_q  <= fe_d;
        end
    end

    assign sck_o = sck_q;
    assign re_o  = re_q;
    assign fe_o  = fe_q;

endmodule

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: master-mode I2S bit/word clock generator with frame-aligned start/stop
module i2s_clkgen
    import i2s_clkgen_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [1:0]           chl_i,
    output logic                 busy_o,
    output logic                 i2s_sck_o,
    output logic                 i2s_ws_o,
    output logic                 sck_re_o,
    output logic                 sck_fe_o,
    output logic                 frame_o
);

    clkgen_state_t        state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q;
    logic [5:0]           len_q;
    logic [4:0]           bit_q, bit_d;
    logic                 ws_q, ws_d, frame_q, frame_d, busy_q, busy_d;
    logic                 fall, start, wrap, fend, run;

    assign run = state_q != I2S_CLKGEN_IDLE;

    i2s_clkdiv #(.DIV_WIDTH(DIV_WIDTH)) u_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (run),
        .div_i  (div_q),
        .sck_o  (i2s_sck_o),
        .re_o   (sck_re_o),
        .fe_o   (sck_fe_o),
        .fall_o (fall)
    );

    // frame end is the ws 1->0 toggle; busy lingers one cycle past it when stopping
    always_comb begin
        start   = (state_q == I2S_CLKGEN_IDLE) && en_i;
        wrap    = fall && ({1'b0, bit_q} == len_q - 6'd1);
        fend    = wrap && ws_q;
        state_d = state_q == I2S_CLKGEN_IDLE ? (en_i ? I2S_CLKGEN_RUN : I2S_CLKGEN_IDLE) :
                  state_q == I2S_CLKGEN_RUN  ? (en_i ? I2S_CLKGEN_RUN : I2S_CLKGEN_STOP) :
                  en_i ? I2S_CLKGEN_RUN : fend ? I2S_CLKGEN_IDLE : I2S_CLKGEN_STOP;
        bit_d   = start ? 5'd0 : !fall ? bit_q : wrap ? 5'd0 : bit_q + 5'd1;
        ws_d    = !start && (ws_q ^ wrap);
        frame_d = start || (fend && state_d != I2S_CLKGEN_IDLE);
        busy_d  = run || state_d != I2S_CLKGEN_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= I2S_CLKGEN_IDLE;
            div_q   <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            ws_q    <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            ws_q    <= ws_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
            if (start || fend) begin
                div_q <= div_i;
                len_q <= slot_len(chl_i);
            end
        end
    end

    assign i2s_ws_o = ws_q;
    assign frame_o  = frame_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_i2s_clkgen.sv
// tb_i2s_clkgen: directed checks of sck/ws timing, frame cadence, shadowing, stop and reset
module tb_i2s_clkgen;

    logic        clk_i, rst_i, en_i;
    logic [15:0] div_i;
    logic [1:0]  chl_i;
    logic        busy_o, i2s_sck_o, i2s_ws_o, sck_re_o, sck_fe_o, frame_o;

    int total, bad, cyc, bfall, both, edgebad;
    int fr[$], wc[$], rq[$], fq[$];

    i2s_clkgen #(.DIV_WIDTH(16)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .div_i     (div_i),
        .chl_i     (chl_i),
        .busy_o    (busy_o),
        .i2s_sck_o (i2s_sck_o),
        .i2s_ws_o  (i2s_ws_o),
        .sck_re_o  (sck_re_o),
        .sck_fe_o  (sck_fe_o),
        .frame_o   (frame_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int first_after(input int q[$], input int t);
        foreach (q[i]) if (q[i] > t) return q[i];
        return -1;
    endfunction

    function automatic int count_in(input int q[$], input int lo, input int hi);
        int n = 0;
        foreach (q[i]) if (q[i] > lo && q[i] < hi) n++;
        return n;
    endfunction

    task automatic clr();
        fr.delete(); wc.delete(); rq.delete(); fq.delete();
        bfall = -1; both = 0; edgebad = 0;
    endtask

    task automatic watch(input int n);
        logic pws, pb, ps;
        for (int i = 0; i < n; i++) begin
            pws = i2s_ws_o; pb = busy_o; ps = i2s_sck_o;
            @(posedge clk_i); #1;
            cyc++;
            if (frame_o) fr.push_back(cyc);
            if (i2s_ws_o !== pws) wc.push_back(cyc);
            if (sck_re_o) rq.push_back(cyc);
            if (sck_fe_o) fq.push_back(cyc);
            if (pb && !busy_o) bfall = cyc;
            if (sck_re_o && sck_fe_o) both++;
            if (sck_re_o !== (i2s_sck_o && !ps) || sck_fe_o !== (!i2s_sck_o && ps)) edgebad++;
        end
    endtask

    task automatic start_run(input logic [15:0] d, input logic [1:0] c, input string tag);
        en_i = 1'b0; rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; div_i = d; chl_i = c; en_i = 1'b1;
        @(posedge clk_i); #1;
        cyc = 0;
        chk({tag, "_frame0"}, frame_o, 1);
        chk({tag, "_busy0"}, busy_o, 1);
        chk({tag, "_sck0"}, i2s_sck_o, 0);
        chk({tag, "_ws0"}, i2s_ws_o, 0);
        clr();
    endtask

    initial begin
        int n;
        total = 0; bad = 0; cyc = 0;
        rst_i = 1'b1; en_i = 1'b0; div_i = 16'd1; chl_i = 2'd0;
        #12;
        chk("rst_sck", i2s_sck_o, 0);
        chk("rst_ws", i2s_ws_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_frame", frame_o, 0);
        chk("rst_re", sck_re_o, 0);
        chk("rst_fe", sck_fe_o, 0);

        start_run(16'd1, 2'd0, "t1");
        watch(130);
        chk("t1_re0", at(rq, 0), 2);
        chk("t1_fe0", at(fq, 0), 4);
        chk("t1_ws_rise", at(wc, 0), 32);
        chk("t1_ws_fall", at(wc, 1), 64);
        chk("t1_frame1", at(fr, 0), 64);
        chk("t1_frame2", at(fr, 1), 128);
        chk("t1_nframes", fr.size(), 2);
        chk("t1_both", both, 0);
        chk("t1_edges", edgebad, 0);

        start_run(16'd0, 2'd3, "t2");
        watch(260);
        chk("t2_re0", at(rq, 0), 1);
        chk("t2_ws_rise", at(wc, 0), 64);
        chk("t2_ws_high", at(wc, 1) - at(wc, 0), 64);
        chk("t2_frame1", at(fr, 0), 128);
        chk("t2_frame2", at(fr, 1), 256);
        chk("t2_re_per_frame", count_in(rq, 128, 256), 64);
        chk("t2_both", both, 0);
        chk("t2_edges", edgebad, 0);

        start_run(16'd1, 2'd0, "t3");
        watch(10);
        div_i = 16'd3; chl_i = 2'd1;
        watch(330);
        chk("t3_ws_old", at(wc, 0), 32);
        chk("t3_frame1", at(fr, 0), 64);
        chk("t3_re_new", first_after(rq, 64), 68);
        chk("t3_fe_new", first_after(fq, 64), 72);
        chk("t3_ws_new", at(wc, 2), 192);
        chk("t3_frame2", at(fr, 1), 320);
        chk("t3_edges", edgebad, 0);

        start_run(16'd1, 2'd0, "t4");
        watch(10);
        en_i = 1'b0;
        watch(100);
        chk("t4_ws_rise", at(wc, 0), 32);
        chk("t4_ws_fall", at(wc, 1), 64);
        chk("t4_nframes", fr.size(), 0);
        chk("t4_busy_fall", bfall, 65);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); #1;
            if (i2s_sck_o || i2s_ws_o || busy_o || frame_o || sck_re_o) n++;
        end
        chk("t4_quiet", n, 0);

        start_run(16'd1, 2'd0, "t5");
        watch(10);
        en_i = 1'b0;
        watch(10);
        en_i = 1'b1;
        watch(182);
        chk("t5_frame1", at(fr, 0), 64);
        chk("t5_frame2", at(fr, 1), 128);
        chk("t5_frame3", at(fr, 2), 192);
        chk("t5_busy_held", bfall, -1);
        chk("t5_sck_pre", i2s_sck_o, 1);

        rst_i = 1'b1;
        #1;
        chk("t6_sck", i2s_sck_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_ws", i2s_ws_o, 0);
        chk("t6_re", sck_re_o, 0);
        #2;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("t6_frame", frame_o, 1);
        chk("t6_busy_up", busy_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
